// File: rtl/mp3dec_pkg.sv
// Shared definitions for the MP3 decoder control path: sequencer state
// encoding and interrupt bit positions, also used by the AHB register map.
package mp3dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_HOLD = 3'd1,
        ST_RST_WAIT = 3'd2,
        ST_READY    = 3'd3,
        ST_RUN      = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_ERROR    = 3'd6
    } mp3dec_state_t;

    localparam int IRQ_LO = 0;  // input FIFO below low watermark
    localparam int IRQ_HI = 1;  // output FIFO at/above high watermark
    localparam int IRQ_TO = 2;  // FIFO reset-busy release timed out
    localparam int IRQ_W  = 3;

    // True while the FIFOs/decoder are being reset; the bus is stalled and
    // watermark flags are suppressed in these states.
    function automatic logic in_reset_seq(input mp3dec_state_t s);
        return (s == ST_RST_HOLD) || (s == ST_RST_WAIT);
    endfunction

endpackage

// File: rtl/mp3dec_irq.sv
// Interrupt block: watermark edge detection, sticky W1C status with
// set-over-clear priority, and the masked, registered interrupt line.
module mp3dec_irq
    import mp3dec_pkg::*;
(
    input  logic             HCLK,
    input  logic             HRST,
    input  logic             lo_flag,
    input  logic             hi_flag,
    input  logic             to_set,
    input  logic [IRQ_W-1:0] irq_mask,
    input  logic [IRQ_W-1:0] irq_clr,
    output logic [IRQ_W-1:0] irq_status,
    output logic             MP3DEC_INTR
);

    logic             lo_q, lo_d;
    logic             hi_q, hi_d;
    logic [IRQ_W-1:0] set_vec;

    // Register the watermark flags, then keep one more stage for edge detect.
    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            lo_q <= 1'b0;
            lo_d <= 1'b0;
            hi_q <= 1'b0;
            hi_d <= 1'b0;
        end else begin
            // NOTE: non-blocking so lo_d captures the old lo_q, not the new one.
            lo_q <= lo_flag;
            lo_d <= lo_q;
            hi_q <= hi_flag;
            hi_d <= hi_q;
        end
    end

    // Rising edges of the registered flags plus the timeout pulse.
    always_comb begin
        // NOTE: default first so every path assigns set_vec and no latch forms.
        set_vec         = '0;
        set_vec[IRQ_LO] = lo_q & ~lo_d;
        set_vec[IRQ_HI] = hi_q & ~hi_d;
        set_vec[IRQ_TO] = to_set;
    end

    // Sticky status; a set arriving with a clear on the same bit wins.
    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~irq_clr) | set_vec;
        end
    end

    // Interrupt line follows the unmasked status one cycle later.
    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            MP3DEC_INTR <= 1'b0;
        end else begin
            MP3DEC_INTR <= |(irq_status & ~irq_mask);
        end
    end

endmodule

// File: rtl/mp3dec_seq.sv
// Control sequencer for the MP3 decoder subsystem: FIFO/decoder reset
// sequence with busy-release timeout, decoder start/stop/drain, and the
// interrupt sources feeding mp3dec_irq.
module mp3dec_seq
    import mp3dec_pkg::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int TIMEOUT    = 1023,
    parameter int CNT_W      = 10
) (
    input  logic             HCLK,
    input  logic             HRST,
    input  logic             cmd_reset,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic [CNT_W-1:0] ififo_cnt,
    input  logic [CNT_W-1:0] ofifo_cnt,
    input  logic [CNT_W-1:0] ififo_lwm,
    input  logic [CNT_W-1:0] ofifo_hwm,
    input  logic             ofifo_empty,
    input  logic             ififo_wrrst_busy,
    input  logic             ofifo_rdrst_busy,
    input  logic [IRQ_W-1:0] irq_mask,
    input  logic [IRQ_W-1:0] irq_clr,
    output logic             dec_rst,
    output logic             dec_en,
    output logic             ahb_stall,
    output logic [2:0]       state,
    output logic [IRQ_W-1:0] irq_status,
    output logic             MP3DEC_INTR
);

    // The sequence counter serves both the hold and the wait phase, so it is
    // sized for the longer of the two.
    localparam int CNT_MAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
    localparam int SEQ_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(RST_CYCLES - 1);
    localparam logic [SEQ_W-1:0] WAIT_LAST = SEQ_W'(TIMEOUT);
    localparam logic [SEQ_W-1:0] SEQ_SAT   = '1;

    mp3dec_state_t    state_q, state_nxt;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_nxt, seq_cnt_inc;
    logic             to_set;
    logic             lo_flag, hi_flag;

    assign seq_cnt_inc = (seq_cnt_q == SEQ_SAT) ? seq_cnt_q : seq_cnt_q + SEQ_W'(1);

    // Next state and counter; the counter clears on every state change.
    always_comb begin
        state_nxt   = state_q;
        seq_cnt_nxt = '0;
        to_set      = 1'b0;
        if (cmd_reset) begin
            state_nxt = ST_RST_HOLD;
        end else begin
            case (state_q)
                ST_RST_HOLD: begin
                    if (seq_cnt_q >= HOLD_LAST) state_nxt = ST_RST_WAIT;
                    else                        seq_cnt_nxt = seq_cnt_inc;
                end
                ST_RST_WAIT: begin
                    if (!ififo_wrrst_busy && !ofifo_rdrst_busy) begin
                        state_nxt = ST_READY;
                    end else if (seq_cnt_q >= WAIT_LAST) begin
                        state_nxt = ST_ERROR;
                        to_set    = 1'b1;
                    end else begin
                        seq_cnt_nxt = seq_cnt_inc;
                    end
                end
                ST_READY: begin
                    if (cmd_start) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (cmd_stop) state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (cmd_start && !cmd_stop) state_nxt = ST_RUN;
                    else if (ofifo_empty)       state_nxt = ST_READY;
                end
                ST_ERROR: begin
                    state_nxt = ST_ERROR;
                end
                default: begin
                    state_nxt = ST_RST_HOLD;
                end
            endcase
        end
    end

    // State and counter registers; power-up lands in the reset hold.
    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            state_q   <= ST_RST_HOLD;
            seq_cnt_q <= '0;
        end else begin
            state_q   <= state_nxt;
            seq_cnt_q <= seq_cnt_nxt;
        end
    end

    // Registered control outputs decoded from the current state.
    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            dec_rst   <= 1'b1;
            dec_en    <= 1'b0;
            ahb_stall <= 1'b1;
        end else begin
            dec_rst   <= (state_q == ST_RST_HOLD);
            dec_en    <= (state_q == ST_RUN);
            ahb_stall <= in_reset_seq(state_q);
        end
    end

    assign state = state_q;

    // Watermark conditions; held low during the reset sequence so no
    // spurious edge is produced when the FIFOs come back.
    assign lo_flag = (ififo_cnt < ififo_lwm) && (state_q == ST_RUN);
    assign hi_flag = (ofifo_cnt >= ofifo_hwm) && !in_reset_seq(state_q);

    mp3dec_irq u_irq (
        .HCLK        (HCLK),
        .HRST        (HRST),
        .lo_flag     (lo_flag),
        .hi_flag     (hi_flag),
        .to_set      (to_set),
        .irq_mask    (irq_mask),
        .irq_clr     (irq_clr),
        .irq_status  (irq_status),
        .MP3DEC_INTR (MP3DEC_INTR)
    );

endmodule

// File: tb/tb_mp3dec_seq.sv
// Scoreboard bench for mp3dec_seq: each stimulus step queues the outputs it
// should produce at a given cycle; a negedge monitor compares them when due.
module tb_mp3dec_seq;

    localparam int RST_CYCLES = 16;
    localparam int TIMEOUT    = 1023;
    localparam int CNT_W      = 10;

    logic             HCLK = 1'b0;
    logic             HRST = 1'b1;
    logic             cmd_reset = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0;
    logic [CNT_W-1:0] ififo_cnt, ofifo_cnt, ififo_lwm, ofifo_hwm;
    logic             ofifo_empty, ififo_wrrst_busy, ofifo_rdrst_busy;
    logic [2:0]       irq_mask, irq_clr;
    logic             dec_rst, dec_en, ahb_stall, MP3DEC_INTR;
    logic [2:0]       state, irq_status;

    mp3dec_seq #(
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .HCLK             (HCLK),
        .HRST             (HRST),
        .cmd_reset        (cmd_reset),
        .cmd_start        (cmd_start),
        .cmd_stop         (cmd_stop),
        .ififo_cnt        (ififo_cnt),
        .ofifo_cnt        (ofifo_cnt),
        .ififo_lwm        (ififo_lwm),
        .ofifo_hwm        (ofifo_hwm),
        .ofifo_empty      (ofifo_empty),
        .ififo_wrrst_busy (ififo_wrrst_busy),
        .ofifo_rdrst_busy (ofifo_rdrst_busy),
        .irq_mask         (irq_mask),
        .irq_clr          (irq_clr),
        .dec_rst          (dec_rst),
        .dec_en           (dec_en),
        .ahb_stall        (ahb_stall),
        .state            (state),
        .irq_status       (irq_status),
        .MP3DEC_INTR      (MP3DEC_INTR)
    );

    always #5 HCLK = ~HCLK;

    typedef enum int {SIG_STATE, SIG_DEC_RST, SIG_DEC_EN, SIG_STALL, SIG_STATUS, SIG_INTR} sig_e;
    typedef struct {
        int          due;
        sig_e        sig;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks = 0;
    int   n_errors = 0;

    // Cycle number = posedges since HRST release.
    always @(posedge HCLK or posedge HRST) begin
        if (HRST) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            SIG_STATE:   return 32'(state);
            SIG_DEC_RST: return 32'(dec_rst);
            SIG_DEC_EN:  return 32'(dec_en);
            SIG_STALL:   return 32'(ahb_stall);
            SIG_STATUS:  return 32'(irq_status);
            default:     return 32'(MP3DEC_INTR);
        endcase
    endfunction

    task automatic sb_push(input int dly, input sig_e s, input logic [31:0] v, input string tag);
        sb.push_back('{cyc + dly, s, v, tag});
    endtask

    // Compare every expectation that has come due.
    always @(negedge HCLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                check(sb[i].tag, sample(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic pulse_cmd(input logic r, input logic s, input logic g);
        cmd_reset = r;
        cmd_stop  = s;
        cmd_start = g;
        tick(1);
        cmd_reset = 1'b0;
        cmd_stop  = 1'b0;
        cmd_start = 1'b0;
    endtask

    task automatic pulse_clr(input logic [2:0] v);
        irq_clr = v;
        tick(1);
        irq_clr = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ififo_cnt        = 10'd65;
        ififo_lwm        = 10'd64;
        ofifo_cnt        = 10'd0;
        ofifo_hwm        = 10'd512;
        ofifo_empty      = 1'b1;
        ififo_wrrst_busy = 1'b1;
        ofifo_rdrst_busy = 1'b1;
        irq_mask         = 3'b000;
        irq_clr          = 3'b000;

        // Reset values while HRST is held.
        tick(3);
        check("rst_state",  32'(state),       1);
        check("rst_decrst", 32'(dec_rst),     1);
        check("rst_decen",  32'(dec_en),      0);
        check("rst_stall",  32'(ahb_stall),   1);
        check("rst_status", 32'(irq_status),  0);
        check("rst_intr",   32'(MP3DEC_INTR), 0);
        HRST = 1'b0;

        // Power-up sequence: 16-cycle hold, busies drop at cycle 5.
        sb_push(15, SIG_STATE,   1, "pu_hold_end");
        sb_push(16, SIG_STATE,   2, "pu_wait");
        sb_push(17, SIG_STATE,   3, "pu_ready");
        sb_push(16, SIG_DEC_RST, 1, "pu_rst_last");
        sb_push(17, SIG_DEC_RST, 0, "pu_rst_low");
        sb_push(17, SIG_STALL,   1, "pu_stall_last");
        sb_push(18, SIG_STALL,   0, "pu_stall_low");
        tick(5);
        ififo_wrrst_busy = 1'b0;
        ofifo_rdrst_busy = 1'b0;
        tick(15);

        // Start, stop into drain, restart from drain, then drain to READY.
        sb_push(1, SIG_STATE,  4, "start_run");
        sb_push(1, SIG_DEC_EN, 0, "start_en_lat");
        sb_push(2, SIG_DEC_EN, 1, "start_en_on");
        pulse_cmd(1'b0, 1'b0, 1'b1);
        tick(3);
        ofifo_empty = 1'b0;
        sb_push(1, SIG_STATE,  5, "stop_drain");
        sb_push(2, SIG_DEC_EN, 0, "stop_en_off");
        sb_push(8, SIG_STATE,  5, "drain_hold");
        pulse_cmd(1'b0, 1'b1, 1'b0);
        tick(7);
        sb_push(1, SIG_STATE, 4, "drain_restart");
        pulse_cmd(1'b0, 1'b0, 1'b1);
        tick(2);
        sb_push(1, SIG_STATE, 5, "drain_again");
        pulse_cmd(1'b0, 1'b1, 1'b0);
        tick(2);
        ofifo_empty = 1'b1;
        sb_push(1, SIG_STATE, 3, "drain_done");
        tick(3);

        // Low watermark in RUN, masked first.
        irq_mask = 3'b001;
        sb_push(1, SIG_STATE, 4, "lo_run");
        pulse_cmd(1'b0, 1'b0, 1'b1);
        tick(3);
        ififo_cnt = 10'd63;
        sb_push(1, SIG_STATUS, 0, "lo_n1");
        sb_push(2, SIG_STATUS, 1, "lo_n2");
        sb_push(3, SIG_INTR,   0, "lo_masked");
        sb_push(5, SIG_INTR,   0, "lo_masked_hold");
        tick(6);
        irq_mask = 3'b000;
        sb_push(1, SIG_INTR, 1, "lo_unmasked");
        tick(3);

        // New rising edge coinciding with a clear: bit stays set.
        ififo_cnt = 10'd65;
        tick(3);
        ififo_cnt = 10'd63;
        sb_push(2, SIG_STATUS, 1, "clr_vs_set");
        sb_push(3, SIG_STATUS, 1, "clr_vs_set_hold");
        tick(1);
        pulse_clr(3'b001);
        tick(3);

        // Plain clear.
        sb_push(1, SIG_STATUS, 0, "lo_clr");
        sb_push(1, SIG_INTR,   1, "lo_intr_lag");
        sb_push(2, SIG_INTR,   0, "lo_intr_clr");
        pulse_clr(3'b001);
        tick(3);

        // All three commands together in RUN, then re-reset mid-hold.
        sb_push(1, SIG_STATE,   1, "multi_hold");
        sb_push(2, SIG_DEC_EN,  0, "multi_en");
        sb_push(2, SIG_DEC_RST, 1, "multi_rst");
        pulse_cmd(1'b1, 1'b1, 1'b1);
        tick(9);
        sb_push(16, SIG_STATE,   1, "rehold_end");
        sb_push(17, SIG_STATE,   2, "rehold_wait");
        sb_push(17, SIG_DEC_RST, 1, "rehold_rst_last");
        sb_push(18, SIG_DEC_RST, 0, "rehold_rst_low");
        pulse_cmd(1'b1, 1'b0, 1'b0);
        tick(19);
        ififo_cnt = 10'd65;

        // Busy stuck high: timeout into ERROR.
        ififo_wrrst_busy = 1'b1;
        sb_push(1040, SIG_STATE,   2, "to_wait");
        sb_push(1040, SIG_STATUS,  0, "to_status_pre");
        sb_push(1041, SIG_STATE,   6, "to_error");
        sb_push(1041, SIG_STATUS,  4, "to_status");
        sb_push(1042, SIG_INTR,    1, "to_intr");
        sb_push(1042, SIG_STALL,   0, "err_stall");
        sb_push(1042, SIG_DEC_RST, 0, "err_decrst");
        pulse_cmd(1'b1, 1'b0, 1'b0);
        tick(1050);
        sb_push(1, SIG_STATE,  6, "err_start_ign");
        sb_push(2, SIG_DEC_EN, 0, "err_start_en");
        pulse_cmd(1'b0, 1'b0, 1'b1);
        tick(2);
        sb_push(1,  SIG_STATE, 1, "err_reset");
        sb_push(2,  SIG_STALL, 1, "err_reset_stall");
        sb_push(18, SIG_STATE, 3, "err_recover");
        pulse_cmd(1'b1, 1'b0, 1'b0);
        tick(5);
        ififo_wrrst_busy = 1'b0;
        tick(14);
        sb_push(1, SIG_STATUS, 0, "to_clr");
        sb_push(2, SIG_INTR,   0, "to_intr_clr");
        pulse_clr(3'b100);
        tick(3);

        // Zero high watermark: fires exactly once after the reset sequence.
        sb_push(1,  SIG_STATE,  1, "hi_reset");
        sb_push(19, SIG_STATUS, 0, "hi_pre");
        sb_push(20, SIG_STATUS, 2, "hi_once");
        sb_push(21, SIG_INTR,   1, "hi_intr");
        pulse_cmd(1'b1, 1'b0, 1'b0);
        ofifo_hwm = 10'd0;
        tick(24);
        sb_push(1, SIG_STATUS, 0, "hi_clr");
        sb_push(6, SIG_STATUS, 0, "hi_no_refire");
        pulse_clr(3'b010);
        tick(8);

        // Let outstanding expectations drain, bounded.
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        check("sb_drain", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
